// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for the EX stage: 32-bit DIV/DIVU, 33-cycle stall, {HI,LO} result.
// The result is held until EX advances; annul aborts the operation without producing a result.
module div_iter_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        annul,
  input  logic        accept,
  output logic        stall_div,
  output logic        ready,
  output logic [63:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
  logic        sdiv_q, sdiv_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic        ready_q, ready_d;
  logic [63:0] result_q, result_d;

  logic [31:0] a_mag, b_mag, r_step, q_step, q_fin, r_fin;
  logic [32:0] shifted;
  logic        take;

  // A magnitude never exceeds 2^31, so 32 bits hold it exactly (0x80000000 negates to itself).
  assign a_mag = (signed_div && a[31]) ? 32'd0 - a : a;
  assign b_mag = (signed_div && b[31]) ? 32'd0 - b : b;

  assign shifted = {rem_q, quo_q[31]};
  assign take    = (shifted >= {1'b0, dvs_q});
  assign r_step  = take ? (shifted[31:0] - dvs_q) : shifted[31:0];
  assign q_step  = {quo_q[30:0], take};

  assign q_fin = bz_q ? 32'hFFFF_FFFF :
                 (sdiv_q && (sa_q ^ sb_q)) ? 32'd0 - q_step : q_step;
  assign r_fin = bz_q ? a_q :
                 (sdiv_q && sa_q) ? 32'd0 - r_step : r_step;

  assign stall_div = !rst && (((state_q == IDLE) && start && !annul) || (state_q == BUSY));
  assign ready     = ready_q;
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    a_d      = a_q;
    sdiv_d   = sdiv_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    ready_d  = ready_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start && !annul) begin
        state_d = BUSY;
        cnt_d   = 5'd0;
        rem_d   = 32'd0;
        quo_d   = a_mag;
        dvs_d   = b_mag;
        a_d     = a;
        sdiv_d  = signed_div;
        sa_d    = a[31];
        sb_d    = b[31];
        bz_d    = (b == 32'd0);
      end
      BUSY: begin
        rem_d = r_step;
        quo_d = q_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = {r_fin, q_fin};
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: if (accept) begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything; a result being finished this cycle is dropped.
    if (annul) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      a_q      <= 32'd0;
      sdiv_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      sdiv_q   <= sdiv_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end
endmodule
